opu_accumulator: RTL and testbench

OPU_ACCUMULATOR -- requirements
Module: opu_accumulator

---
 rtl/opu_accumulator.sv | 139 +++++++++++++
 tb/tb_opu_accumulator.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opu_accumulator.sv
// opu_accumulator: accumulates packed signed products (2x16-bit or 4x8-bit lanes) into ACC_W-bit lanes.
// Optional macro OPU_ACC_SAT_EN selects clamping lane adders with an out_sat report; default is wrapping.
module opu_accumulator #(
    parameter int ACC_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        in_p,
    input  logic               in_mode,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [4*ACC_W-1:0] out_acc,
    output logic               out_mode,
    output logic [7:0]         out_cnt,
    output logic               out_sat,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef enum logic {GROUP_IDLE, GROUP_ACC} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc  [4];
    logic [ACC_W-1:0] lane [4];
    logic [ACC_W-1:0] sum  [4];
    logic [7:0]       cnt;
    logic [7:0]       cnt_next;
    logic             mode_q;
    logic             cur_mode;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    // The first beat of a group decides the packing; later beats reuse the latched mode.
    assign cur_mode = (state == GROUP_IDLE) ? in_mode : mode_q;
    assign cnt_next = (cnt == 8'd255) ? cnt : cnt + 8'd1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane[i] = '0;
        end
        if (cur_mode) begin
            for (int i = 0; i < 4; i++) begin
                lane[i] = {{(ACC_W-8){in_p[8*i+7]}}, in_p[8*i +: 8]};
            end
        end else begin
            lane[0] = {{(ACC_W-16){in_p[15]}}, in_p[15:0]};
            lane[1] = {{(ACC_W-16){in_p[31]}}, in_p[31:16]};
        end
    end

`ifdef OPU_ACC_SAT_EN
    logic [ACC_W:0] wide [4];
    logic           beat_sat;
    logic           group_sat;
    logic           sat_q;

    // One guard bit per lane: overflow shows up as the top two bits disagreeing.
    always_comb begin
        beat_sat = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wide[i] = {acc[i][ACC_W-1], acc[i]} + {lane[i][ACC_W-1], lane[i]};
            sum[i]  = wide[i][ACC_W-1:0];
            if (wide[i][ACC_W] != wide[i][ACC_W-1]) begin
                sum[i]   = wide[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                beat_sat = 1'b1;
            end
        end
    end

    assign group_sat = sat_q || beat_sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q   <= 1'b0;
            out_sat <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                sat_q   <= 1'b0;
                out_sat <= group_sat;
            end else begin
                sat_q   <= group_sat;
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sum[i] = acc[i] + lane[i];
        end
    end

    assign out_sat = 1'b0;
`endif

    // A completing beat loads the result registers and clears the group in the same edge,
    // so a fresh group can start on the very next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= GROUP_IDLE;
            for (int i = 0; i < 4; i++) begin
                acc[i] <= '0;
            end
            cnt       <= 8'd0;
            mode_q    <= 1'b0;
            out_acc   <= '0;
            out_mode  <= 1'b0;
            out_cnt   <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                if (in_last) begin
                    for (int i = 0; i < 4; i++) begin
                        out_acc[i*ACC_W +: ACC_W] <= sum[i];
                        acc[i]                    <= '0;
                    end
                    out_mode  <= cur_mode;
                    out_cnt   <= cnt_next;
                    out_valid <= 1'b1;
                    cnt       <= 8'd0;
                    mode_q    <= 1'b0;
                    state     <= GROUP_IDLE;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        acc[i] <= sum[i];
                    end
                    cnt    <= cnt_next;
                    mode_q <= cur_mode;
                    state  <= GROUP_ACC;
                end
            end
        end
    end

endmodule

// File: tb/tb_opu_accumulator.sv
// Testbench for opu_accumulator: ACC_W=24 and ACC_W=17 instances share stimulus; a reference
// model pushes expected group results into a scoreboard that is popped on each output transfer.
module tb_opu_accumulator;

`ifdef OPU_ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_p;
    logic        in_mode;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [95:0] out_acc;
    logic        out_mode;
    logic [7:0]  out_cnt;
    logic        out_sat;
    logic        out_valid;
    logic        out_ready;

    logic        in_ready17;
    logic [67:0] out_acc17;
    logic        out_mode17;
    logic [7:0]  out_cnt17;
    logic        out_sat17;
    logic        out_valid17;

    always #5 clk = ~clk;

    opu_accumulator #(.ACC_W(24)) dut (
        .clk(clk), .reset(reset), .in_p(in_p), .in_mode(in_mode), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_acc(out_acc), .out_mode(out_mode),
        .out_cnt(out_cnt), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready)
    );

    opu_accumulator #(.ACC_W(17)) dut17 (
        .clk(clk), .reset(reset), .in_p(in_p), .in_mode(in_mode), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready17), .out_acc(out_acc17), .out_mode(out_mode17),
        .out_cnt(out_cnt17), .out_sat(out_sat17), .out_valid(out_valid17), .out_ready(out_ready)
    );

    typedef struct {
        logic [95:0] acc24;
        logic [67:0] acc17;
        logic        mode;
        logic [7:0]  cnt;
        logic        sat24;
        logic        sat17;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint m24 [4];
    longint m17 [4];
    bit     msat24, msat17, m_active, m_mode;
    int     m_cnt;

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] w24(input int v);
        return v[23:0];
    endfunction

    function automatic logic [16:0] w17(input int v);
        return v[16:0];
    endfunction

    function automatic longint lane_val(input logic [31:0] p, input logic mode, input int i);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        if (mode) begin
            b = p[8*i +: 8];
            return longint'(b);
        end
        if (i == 0) begin
            h = p[15:0];
            return longint'(h);
        end
        if (i == 1) begin
            h = p[31:16];
            return longint'(h);
        end
        return 0;
    endfunction

    function automatic bit clipped(input longint v, input int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -(longint'(1) << (w - 1));
        return SAT_EN && (v > hi || v < lo);
    endfunction

    function automatic longint fit(input longint v, input int w);
        longint hi = (longint'(1) << (w - 1)) - 1;
        longint lo = -(longint'(1) << (w - 1));
        longint t;
        if (SAT_EN) return (v > hi) ? hi : ((v < lo) ? lo : v);
        t = v & ((longint'(1) << w) - 1);
        if (t > hi) t = t - (longint'(1) << w);
        return t;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m24[i] = 0;
            m17[i] = 0;
        end
        msat24   = 1'b0;
        msat17   = 1'b0;
        m_active = 1'b0;
        m_mode   = 1'b0;
        m_cnt    = 0;
    endtask

    // Scoreboard: pop/compare on an output transfer, then fold an accepted beat into the model.
    always @(negedge clk) begin
        exp_t   e;
        longint v;
        if (reset) begin
            model_clear();
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                check_output("sb_has_entry", 128'(sb.size() > 0), 128'(1));
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_output("sb_acc24", 128'(out_acc), 128'(e.acc24));
                    check_output("sb_acc17", 128'(out_acc17), 128'(e.acc17));
                    check_output("sb_mode", 128'(out_mode), 128'(e.mode));
                    check_output("sb_cnt", 128'(out_cnt), 128'(e.cnt));
                    check_output("sb_sat24", 128'(out_sat), 128'(e.sat24));
                    check_output("sb_sat17", 128'(out_sat17), 128'(e.sat17));
                    check_output("sb_valid17", 128'(out_valid17), 128'(1));
                end
            end
            if (in_valid && in_ready) begin
                if (!m_active) begin
                    m_mode   = in_mode;
                    m_active = 1'b1;
                end
                for (int i = 0; i < 4; i++) begin
                    v      = m24[i] + lane_val(in_p, m_mode, i);
                    msat24 = msat24 | clipped(v, 24);
                    m24[i] = fit(v, 24);
                    v      = m17[i] + lane_val(in_p, m_mode, i);
                    msat17 = msat17 | clipped(v, 17);
                    m17[i] = fit(v, 17);
                end
                m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
                if (in_last) begin
                    for (int i = 0; i < 4; i++) begin
                        e.acc24[i*24 +: 24] = m24[i][23:0];
                        e.acc17[i*17 +: 17] = m17[i][16:0];
                    end
                    e.mode  = m_mode;
                    e.cnt   = 8'(m_cnt);
                    e.sat24 = msat24;
                    e.sat17 = msat17;
                    sb.push_back(e);
                    model_clear();
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic apply_stimulus(input logic [31:0] p, input logic mode, input logic last);
        bit ok = 1'b0;
        in_p     = p;
        in_mode  = mode;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            ok = in_ready;
            next_cycle();
            if (ok) break;
            out_ready = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_output("beat_accepted", 128'(ok), 128'(1));
    endtask

    initial begin
        logic [95:0] exp35;
        logic [95:0] exp_hold;
        logic [31:0] r;

        reset     = 1'b1;
        in_p      = '0;
        in_mode   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        check_output("rst_valid", 128'(out_valid), 128'(0));
        check_output("rst_acc", 128'(out_acc), 128'(0));
        check_output("rst_cnt", 128'(out_cnt), 128'(0));
        check_output("rst_mode", 128'(out_mode), 128'(0));
        check_output("rst_sat", 128'(out_sat), 128'(0));
        check_output("rst_acc17", 128'(out_acc17), 128'(0));
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_output("ready_after_reset", 128'(in_ready), 128'(1));
        next_cycle();

        // 8-bit lanes, three beats
        repeat (2) apply_stimulus(32'h01FF7F80, 1'b1, 1'b0);
        apply_stimulus(32'h01FF7F80, 1'b1, 1'b1);
        @(negedge clk);
        exp35 = {w24(3), w24(-3), w24(381), w24(-384)};
        check_output("m1_valid_latency", 128'(out_valid), 128'(1));
        check_output("m1_acc", 128'(out_acc), 128'(exp35));
        check_output("m1_cnt", 128'(out_cnt), 128'(3));
        check_output("m1_mode", 128'(out_mode), 128'(1));
        next_cycle();

        // 16-bit lanes; in_mode flips on the second beat and must be ignored
        apply_stimulus(32'h7FFF8000, 1'b0, 1'b0);
        apply_stimulus(32'h00010001, 1'b1, 1'b1);
        @(negedge clk);
        check_output("m0_lane0", 128'(out_acc[23:0]), 128'(w24(-32767)));
        check_output("m0_lane1", 128'(out_acc[47:24]), 128'(w24(32768)));
        check_output("m0_lane23", 128'(out_acc[95:48]), 128'(0));
        check_output("m0_mode", 128'(out_mode), 128'(0));
        next_cycle();

        // Backpressure: pending result held, then replaced with no dead cycle
        out_ready = 1'b0;
        apply_stimulus(32'h00000102, 1'b1, 1'b1);
        exp_hold = {w24(0), w24(0), w24(1), w24(2)};
        in_p     = 32'h00000304;
        in_mode  = 1'b1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output("stall_ready", 128'(in_ready), 128'(0));
            check_output("stall_valid", 128'(out_valid), 128'(1));
            check_output("stall_acc", 128'(out_acc), 128'(exp_hold));
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check_output("release_ready", 128'(in_ready), 128'(1));
        next_cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check_output("replace_valid", 128'(out_valid), 128'(1));
        check_output("replace_lane0", 128'(out_acc[23:0]), 128'(24'd4));
        next_cycle();

        // Saturation boundary on the 17-bit instance
        repeat (2) apply_stimulus(32'h00007FFF, 1'b0, 1'b0);
        apply_stimulus(32'h00007FFF, 1'b0, 1'b1);
        @(negedge clk);
        check_output("sat17_lane0", 128'(out_acc17[16:0]), SAT_EN ? 128'(17'd65535) : 128'(w17(-32771)));
        check_output("sat17_flag", 128'(out_sat17), 128'(SAT_EN));
        check_output("sat24_lane0", 128'(out_acc[23:0]), 128'(24'd98301));
        check_output("sat24_flag", 128'(out_sat), 128'(0));
        next_cycle();

        // Reset mid-group, with a last beat offered during the reset cycle
        repeat (2) apply_stimulus(32'h00000007, 1'b1, 1'b0);
        reset    = 1'b1;
        in_p     = 32'h00000007;
        in_mode  = 1'b1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        next_cycle();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check_output("midrst_valid", 128'(out_valid), 128'(0));
        check_output("midrst_ready", 128'(in_ready), 128'(1));
        next_cycle();
        apply_stimulus(32'h00000005, 1'b1, 1'b1);
        @(negedge clk);
        check_output("midrst_lane0", 128'(out_acc[23:0]), 128'(24'd5));
        check_output("midrst_cnt", 128'(out_cnt), 128'(1));
        next_cycle();

        // Beat counter saturation over a 300-beat group
        repeat (299) apply_stimulus(32'h00000001, 1'b1, 1'b0);
        apply_stimulus(32'h00000001, 1'b1, 1'b1);
        @(negedge clk);
        check_output("long_cnt", 128'(out_cnt), 128'(255));
        check_output("long_lane0", 128'(out_acc[23:0]), 128'(24'd300));
        next_cycle();

        // Random mix of packing, group lengths and downstream stalls
        for (int k = 0; k < 40; k++) begin
            r = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            apply_stimulus(r, 1'($urandom_range(0, 1)), (k == 39) || ($urandom_range(0, 3) == 0));
        end

        out_ready = 1'b1;
        repeat (4) next_cycle();
        @(negedge clk);
        check_output("sb_drained", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
